salsa_stream_ctrl: RTL and testbench
====================================

SALSA_STREAM_CTRL -- requirements
Module: salsa_stream_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles CORE_BUSY may stay high in one wait before a fault.
REQ-002 SHALL have ports: CLK  in  1  single clock, all state on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 CFG_READY  out  1  high when a config request will be accepted.
REQ-005 CFG_KEY  in  1  load KEY_IN, sampled when CFG_READY is high; KEY_IN  in  256  key.
REQ-006 CFG_IV  in  1  load IV_IN, sampled when CFG_READY is high; IV_IN  in  128  {counter[127:64], nonce[63:0]}.
REQ-007 IN_VALID / IN_READY  in/out  1/1  input word handshake; IN_DATA  in  128  plaintext or ciphertext.
REQ-008 OUT_VALID / OUT_READY  out/in  1/1  output handshake; OUT_DATA  out  128  IN_DATA XOR keystream word.
REQ-009 CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC  out  1 each  one-cycle command pulses to the Salsa20 core.
REQ-010 CORE_KEY_IN  out  256 and CORE_DATA_IN  out  128  driven from internal key and IV registers.
REQ-011 CORE_BUSY  in  1 and CORE_DATA_OUT  in  128  core status and keystream word.
REQ-012 ERR  out  1  sticky core-timeout flag.

Function
REQ-013 SHALL implement states IDLE, KEY_CMD, IV_CMD, DRAIN_CMD, GEN_CMD, WAIT, OUT.
REQ-014 IDLE SHALL assert CFG_READY when OUT_VALID is 0.
REQ-015 IDLE SHALL assert IN_READY only when key_ok, iv_ok and CFG_READY are all 1, and CFG_KEY and CFG_IV are both 0.
REQ-016 Priority in IDLE SHALL be CFG_KEY, then CFG_IV, then an input word; lower-priority requests in the same cycle are not accepted.
REQ-017 CFG_KEY SHALL latch KEY_IN, pulse CORE_SET_KEY for 1 cycle in KEY_CMD, then WAIT, then set key_ok.
REQ-018 CFG_IV SHALL latch IV_IN, pulse CORE_SET_COUNT in IV_CMD, then WAIT, then set iv_ok.
REQ-019 A 2-bit word_idx SHALL mirror the core output position.
REQ-020 Any config request accepted with word_idx != 0 SHALL first issue (4 - word_idx) discard START_ENC pulses via DRAIN_CMD/WAIT, discarding CORE_DATA_OUT, until word_idx == 0. The config command is issued only after that.
REQ-021 On accepting an input word, the block SHALL latch IN_DATA, pulse CORE_START_ENC in GEN_CMD, then enter WAIT.
REQ-022 WAIT SHALL exit on the first cycle CORE_BUSY == 0; commands are registered, so CORE_BUSY is already high in the first WAIT cycle.
REQ-023 On leaving WAIT for a data word, the block SHALL register OUT_DATA = latched IN_DATA ^ CORE_DATA_OUT, set OUT_VALID, and increment word_idx mod 4.
REQ-024 OUT_VALID and OUT_DATA SHALL hold until OUT_VALID && OUT_READY, then clear OUT_VALID and return to IDLE.
REQ-025 Each command pulse SHALL be exactly one cycle; at most one command is outstanding.
REQ-026 CORE_KEY_IN and CORE_DATA_IN SHALL stay stable from command pulse to WAIT exit.
REQ-027 Latency with the team core: word 0 of a block SHALL give OUT_VALID 26 edges after acceptance; words 1-3 SHALL give it 3 edges after acceptance.
REQ-028 A new CFG_IV SHALL reset the keystream position; the core auto-increments the block counter after each block, and the controller SHALL NOT reload the IV itself.

Reset
REQ-029 RST_N low SHALL asynchronously force IDLE, word_idx=0, key_ok=iv_ok=0, ERR=0, OUT_VALID=0, OUT_DATA=0, all CORE_* pulses 0, and key/IV registers 0.
REQ-030 Reset SHALL be applied to the core and this block together, so word_idx stays aligned with the core.

Configuration
REQ-031 Macro SALSA_CTRL_TIMEOUT_EN defined: WAIT SHALL count cycles with CORE_BUSY high.
REQ-032 With the macro, reaching TIMEOUT SHALL set ERR, clear key_ok and iv_ok, clear word_idx, and return to IDLE with no output. ERR clears only on reset.
REQ-033 Macro undefined: ERR SHALL be tied 0 and WAIT is unbounded.

Verification
REQ-034 Key=0, IV=0, four input words of 0 -> OUT_DATA equals the 64-byte Salsa20 zero-key/zero-nonce keystream, in order, word 0 first.
REQ-035 Same key/IV, IN_DATA=ciphertext from REQ-034 with 0xFFFF..FF plaintext -> OUT_DATA all ones; word-0 latency 26 edges, words 1-3 latency 3 edges.
REQ-036 After 2 words, CFG_IV -> exactly 2 discard CORE_START_ENC pulses, then one CORE_SET_COUNT; the next word uses block 0 of the new IV.
REQ-037 OUT_READY held low 10 cycles -> OUT_DATA stable, IN_READY low, no CORE_* pulses.
REQ-038 CFG_KEY and IN_VALID high in the same cycle -> key load first, word not accepted; assert RST_N low mid-WAIT -> all outputs at reset values the same cycle.
REQ-039 With SALSA_CTRL_TIMEOUT_EN, CORE_BUSY stuck high -> ERR=1 after 64 cycles, IN_READY=0 until key and IV are reloaded.

Source files
------------

// File: rtl/salsa_stream_ctrl.sv
// Salsa20 stream controller: sequences key/IV loads and keystream requests to a Salsa20 core
// and XORs each 128-bit keystream word onto the data. Define SALSA_CTRL_TIMEOUT_EN for the core watchdog.

module salsa_stream_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic         CLK,
   input  logic         RST_N,
   output logic         CFG_READY,
   input  logic         CFG_KEY,
   input  logic [255:0] KEY_IN,
   input  logic         CFG_IV,
   input  logic [127:0] IV_IN,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [127:0] IN_DATA,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [127:0] OUT_DATA,
   output logic         CORE_SET_KEY,
   output logic         CORE_SET_COUNT,
   output logic         CORE_START_ENC,
   output logic [255:0] CORE_KEY_IN,
   output logic [127:0] CORE_DATA_IN,
   input  logic         CORE_BUSY,
   input  logic [127:0] CORE_DATA_OUT,
   output logic         ERR
);

   typedef enum logic [2:0] {IDLE, KEY_CMD, IV_CMD, DRAIN_CMD, GEN_CMD, WAIT, OUT} state_t;
   typedef enum logic [1:0] {OP_DATA, OP_KEY, OP_IV, OP_DRAIN} op_t;

   state_t        state_reg;
   op_t           op_reg;
   logic          pend_iv_reg;
   logic [255:0]  key_reg;
   logic [127:0]  iv_reg;
   logic [127:0]  data_reg;
   logic [127:0]  out_data_reg;
   logic          out_valid_reg;
   logic          key_ok_reg;
   logic          iv_ok_reg;
   logic [1:0]    word_idx_reg;
   logic          set_key_reg;
   logic          set_count_reg;
   logic          start_enc_reg;

`ifdef SALSA_CTRL_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] tmo_reg;
   logic             err_reg;
   assign ERR = err_reg;
`else
   // No watchdog: ERR is constant 0 for any legal TIMEOUT.
   assign ERR = (TIMEOUT < 0);
`endif

   assign CFG_READY      = (state_reg == IDLE) && !out_valid_reg;
   assign IN_READY       = CFG_READY && key_ok_reg && iv_ok_reg && !CFG_KEY && !CFG_IV;
   assign OUT_VALID      = out_valid_reg;
   assign OUT_DATA       = out_data_reg;
   assign CORE_SET_KEY   = set_key_reg;
   assign CORE_SET_COUNT = set_count_reg;
   assign CORE_START_ENC = start_enc_reg;
   assign CORE_KEY_IN    = key_reg;
   assign CORE_DATA_IN   = iv_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg     <= IDLE;
         op_reg        <= OP_DATA;
         pend_iv_reg   <= 1'b0;
         key_reg       <= '0;
         iv_reg        <= '0;
         data_reg      <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         key_ok_reg    <= 1'b0;
         iv_ok_reg     <= 1'b0;
         word_idx_reg  <= 2'd0;
         set_key_reg   <= 1'b0;
         set_count_reg <= 1'b0;
         start_enc_reg <= 1'b0;
`ifdef SALSA_CTRL_TIMEOUT_EN
         tmo_reg       <= '0;
         err_reg       <= 1'b0;
`endif
      end else begin
         set_key_reg   <= 1'b0;
         set_count_reg <= 1'b0;
         start_enc_reg <= 1'b0;
`ifdef SALSA_CTRL_TIMEOUT_EN
         if (state_reg != WAIT)
            tmo_reg <= '0;
`endif
         case (state_reg)
            IDLE: begin
               if (CFG_READY && (CFG_KEY || CFG_IV)) begin
                  pend_iv_reg <= !CFG_KEY;
                  if (CFG_KEY)
                     key_reg <= KEY_IN;
                  else
                     iv_reg <= IV_IN;
                  // Core is mid-block: burn the remaining words so the new config starts on a block boundary.
                  if (word_idx_reg != 2'd0) begin
                     state_reg     <= DRAIN_CMD;
                     op_reg        <= OP_DRAIN;
                     start_enc_reg <= 1'b1;
                  end else if (CFG_KEY) begin
                     state_reg   <= KEY_CMD;
                     op_reg      <= OP_KEY;
                     set_key_reg <= 1'b1;
                  end else begin
                     state_reg     <= IV_CMD;
                     op_reg        <= OP_IV;
                     set_count_reg <= 1'b1;
                  end
               end else if (IN_VALID && IN_READY) begin
                  data_reg      <= IN_DATA;
                  state_reg     <= GEN_CMD;
                  op_reg        <= OP_DATA;
                  start_enc_reg <= 1'b1;
               end
            end
            KEY_CMD, IV_CMD, DRAIN_CMD, GEN_CMD: state_reg <= WAIT;
            WAIT: begin
               if (!CORE_BUSY) begin
                  case (op_reg)
                     OP_DATA: begin
                        out_data_reg  <= data_reg ^ CORE_DATA_OUT;
                        out_valid_reg <= 1'b1;
                        word_idx_reg  <= word_idx_reg + 2'd1;
                        state_reg     <= OUT;
                     end
                     OP_KEY: begin
                        key_ok_reg <= 1'b1;
                        state_reg  <= IDLE;
                     end
                     OP_IV: begin
                        iv_ok_reg <= 1'b1;
                        state_reg <= IDLE;
                     end
                     default: begin
                        word_idx_reg <= word_idx_reg + 2'd1;
                        if (word_idx_reg == 2'd3) begin
                           if (pend_iv_reg) begin
                              state_reg     <= IV_CMD;
                              op_reg        <= OP_IV;
                              set_count_reg <= 1'b1;
                           end else begin
                              state_reg   <= KEY_CMD;
                              op_reg      <= OP_KEY;
                              set_key_reg <= 1'b1;
                           end
                        end else begin
                           state_reg     <= DRAIN_CMD;
                           start_enc_reg <= 1'b1;
                        end
                     end
                  endcase
               end
`ifdef SALSA_CTRL_TIMEOUT_EN
               else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                  err_reg      <= 1'b1;
                  key_ok_reg   <= 1'b0;
                  iv_ok_reg    <= 1'b0;
                  word_idx_reg <= 2'd0;
                  state_reg    <= IDLE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
`endif
            end
            OUT: begin
               if (OUT_READY) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_salsa_stream_ctrl.sv
// Bench for salsa_stream_ctrl: behavioural Salsa20 core plus a keystream-position reference model.
// Covers the SALSA_CTRL_TIMEOUT_EN watchdog when that macro is defined.

module tb_salsa_stream_ctrl;

   localparam int TIMEOUT = 64;

   logic         CLK;
   logic         RST_N;
   logic         CFG_READY, CFG_KEY, CFG_IV;
   logic [255:0] KEY_IN;
   logic [127:0] IV_IN;
   logic         IN_VALID, IN_READY;
   logic [127:0] IN_DATA;
   logic         OUT_VALID, OUT_READY;
   logic [127:0] OUT_DATA;
   logic         CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC;
   logic [255:0] CORE_KEY_IN;
   logic [127:0] CORE_DATA_IN;
   logic         CORE_BUSY;
   logic [127:0] CORE_DATA_OUT;
   logic         ERR;

   int errors = 0;
   int checks = 0;

   logic [255:0] ref_key;
   logic [127:0] ref_iv;
   int           ref_pos;

   salsa_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST_N(RST_N), .CFG_READY(CFG_READY), .CFG_KEY(CFG_KEY), .KEY_IN(KEY_IN),
      .CFG_IV(CFG_IV), .IV_IN(IV_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .CORE_SET_KEY(CORE_SET_KEY), .CORE_SET_COUNT(CORE_SET_COUNT), .CORE_START_ENC(CORE_START_ENC),
      .CORE_KEY_IN(CORE_KEY_IN), .CORE_DATA_IN(CORE_DATA_IN), .CORE_BUSY(CORE_BUSY),
      .CORE_DATA_OUT(CORE_DATA_OUT), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
      return (v << s) | (v >> (32 - s));
   endfunction

   function automatic logic [511:0] salsa_block(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
      logic [31:0] j [16];
      logic [31:0] x [16];
      logic [511:0] r;
      int qi [8][4] = '{'{0,4,8,12}, '{5,9,13,1}, '{10,14,2,6}, '{15,3,7,11},
                         '{0,1,2,3},  '{5,6,7,4},  '{10,11,8,9}, '{15,12,13,14}};
      j[0] = 32'h61707865; j[5] = 32'h3320646e; j[10] = 32'h79622d32; j[15] = 32'h6b206574;
      for (int i = 0; i < 4; i++) begin
         j[1 + i]  = k[32*i +: 32];
         j[11 + i] = k[128 + 32*i +: 32];
      end
      j[6] = n[31:0]; j[7] = n[63:32]; j[8] = c[31:0]; j[9] = c[63:32];
      x = j;
      for (int rd = 0; rd < 10; rd++) begin
         for (int q = 0; q < 8; q++) begin
            int a, b, cc, d;
            a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
            x[b]  = x[b]  ^ rotl(x[a] + x[d], 7);
            x[cc] = x[cc] ^ rotl(x[b] + x[a], 9);
            x[d]  = x[d]  ^ rotl(x[cc] + x[b], 13);
            x[a]  = x[a]  ^ rotl(x[d] + x[cc], 18);
         end
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + j[i];
      return r;
   endfunction

   // Keystream word p since the IV was loaded: block p/4 after the IV's counter, word p%4.
   function automatic logic [127:0] ks_word(input logic [255:0] k, input logic [127:0] iv, input int p);
      logic [511:0] b;
      b = salsa_block(k, iv[63:0], iv[127:64] + 64'(p / 4));
      return b[(p % 4) * 128 +: 128];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rand256();
      return {rand128(), rand128()};
   endfunction

   // Core model: config commands busy 1 cycle, a block computation busy 24, buffered words busy 1.
   logic [255:0] c_key;
   logic [63:0]  c_nonce, c_ctr;
   logic [511:0] c_blk, c_new_blk;
   int           c_pos, c_rem;
   logic         stuck;

   always_comb c_new_blk = salsa_block(c_key, c_nonce, c_ctr);
   assign CORE_BUSY = (c_rem != 0) || stuck;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         c_key <= '0; c_nonce <= '0; c_ctr <= '0; c_blk <= '0;
         c_pos <= 0; c_rem <= 0; CORE_DATA_OUT <= '0;
      end else begin
         if (c_rem > 0) c_rem <= c_rem - 1;
         if (CORE_SET_KEY) begin
            c_key <= CORE_KEY_IN;
            c_rem <= 1;
         end else if (CORE_SET_COUNT) begin
            c_nonce <= CORE_DATA_IN[63:0];
            c_ctr   <= CORE_DATA_IN[127:64];
            c_pos   <= 0;
            c_rem   <= 1;
         end else if (CORE_START_ENC) begin
            if (c_pos == 0) begin
               c_blk         <= c_new_blk;
               CORE_DATA_OUT <= c_new_blk[127:0];
               c_rem         <= 24;
            end else begin
               CORE_DATA_OUT <= c_blk[c_pos*128 +: 128];
               c_rem         <= 1;
            end
            if (c_pos == 3) begin
               c_pos <= 0;
               c_ctr <= c_ctr + 64'd1;
            end else begin
               c_pos <= c_pos + 1;
            end
         end
      end
   end

   // Command log: 1 = START_ENC, 2 = SET_COUNT, 3 = SET_KEY, one entry per asserted cycle.
   int ev_q [$];
   always @(posedge CLK) begin
      if (RST_N) begin
         if (CORE_START_ENC) ev_q.push_back(1);
         if (CORE_SET_COUNT) ev_q.push_back(2);
         if (CORE_SET_KEY)   ev_q.push_back(3);
      end
   end

   task automatic cfg_load(input bit is_iv, input logic [255:0] kv, input logic [127:0] iv, output bit ok);
      int n = 0;
      @(negedge CLK);
      while (!CFG_READY && n < 400) begin @(negedge CLK); n++; end
      ok = CFG_READY;
      if (ok) begin
         if (is_iv) begin CFG_IV = 1'b1; IV_IN = iv; end
         else begin CFG_KEY = 1'b1; KEY_IN = kv; end
         @(posedge CLK); #1;
         CFG_IV = 1'b0; CFG_KEY = 1'b0;
         n = 0;
         while (!CFG_READY && n < 400) begin @(negedge CLK); n++; end
         ok = CFG_READY;
      end
   endtask

   task automatic accept_word(input logic [127:0] d, output bit ok);
      int n = 0;
      @(negedge CLK); IN_VALID = 1'b1; IN_DATA = d; #1;
      while (!IN_READY && n < 400) begin @(negedge CLK); #1; n++; end
      ok = IN_READY;
      if (ok) begin @(posedge CLK); #1; end
      IN_VALID = 1'b0;
   endtask

   task automatic send_word(input logic [127:0] d, output int lat, output bit ok);
      int n = 0;
      lat = 0;
      accept_word(d, ok);
      if (ok) begin
         while (!OUT_VALID && n < 400) begin @(posedge CLK); #1; lat++; n++; end
         ok = OUT_VALID;
      end
   endtask

   task automatic take_out(input int stall);
      repeat (stall) @(negedge CLK);
      @(negedge CLK); OUT_READY = 1'b1;
      @(posedge CLK); #1; OUT_READY = 1'b0;
   endtask

   task automatic load_key_iv(input logic [255:0] k, input logic [127:0] iv);
      bit ok;
      cfg_load(1'b0, k, '0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cfg_key_done: got timeout required CFG_READY"); end
      ref_key = k;
      ref_pos = ((ref_pos + 3) / 4) * 4;
      cfg_load(1'b1, '0, iv, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cfg_iv_done: got timeout required CFG_READY"); end
      ref_iv  = iv;
      ref_pos = 0;
   endtask

   // Send one word, check data and latency against the reference, then drain the output.
   task automatic word_check(input string tag, input logic [127:0] d, input logic [127:0] expv, input int stall);
      int lat, exp_lat;
      bit ok;
      exp_lat = (ref_pos % 4 == 0) ? 26 : 3;
      send_word(d, lat, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_handshake: got no OUT_VALID required OUT_VALID=1", tag); end
      checks++;
      if (OUT_DATA !== expv) begin errors++; $display("FAIL %s_data: got %h required %h", tag, OUT_DATA, expv); end
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d required %0d", tag, lat, exp_lat); end
      $display("%s pos=%0d in=%h out=%h lat=%0d", tag, ref_pos, d, OUT_DATA, lat);
      take_out(stall);
      ref_pos++;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; CFG_KEY = 0; CFG_IV = 0; KEY_IN = '0; IV_IN = '0;
      IN_VALID = 0; IN_DATA = '0; OUT_READY = 0; stuck = 0;
      ref_key = '0; ref_iv = '0; ref_pos = 0;
      repeat (3) @(posedge CLK); #1;
      checks++;
      if ({OUT_VALID, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 00000", {OUT_VALID, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC});
      end
      @(negedge CLK); RST_N = 1'b1; #1;
      checks++;
      if (CFG_READY !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b required 1", CFG_READY); end
      checks++;
      if (IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", IN_READY); end
      checks++;
      if ({OUT_DATA, CORE_KEY_IN, CORE_DATA_IN} !== '0) begin errors++; $display("FAIL reset_data: got nonzero required 0"); end
      $display("reset done");
   endtask

   task automatic test_zero_keystream();
      load_key_iv('0, '0);
      for (int w = 0; w < 4; w++) word_check("zero_ks", '0, ks_word('0, '0, ref_pos), 0);
   endtask

   task automatic test_decrypt_latency();
      bit ok;
      cfg_load(1'b1, '0, '0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL decrypt_iv: got timeout required CFG_READY"); end
      ref_pos = 0;
      for (int w = 0; w < 4; w++)
         word_check("decrypt", ks_word('0, '0, w) ^ {128{1'b1}}, {128{1'b1}}, $urandom_range(0, 3));
   endtask

   task automatic test_random();
      logic [127:0] d;
      load_key_iv(rand256(), rand128());
      for (int w = 0; w < 6; w++) begin
         d = rand128();
         word_check("random", d, d ^ ks_word(ref_key, ref_iv, ref_pos), $urandom_range(0, 3));
      end
   endtask

   task automatic test_iv_drain();
      logic [127:0] d, iv_b;
      bit ok;
      load_key_iv(rand256(), rand128());
      for (int w = 0; w < 2; w++) begin
         d = rand128();
         word_check("pre_drain", d, d ^ ks_word(ref_key, ref_iv, ref_pos), 0);
      end
      ev_q.delete();
      iv_b = rand128();
      cfg_load(1'b1, '0, iv_b, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL drain_cfg: got timeout required CFG_READY"); end
      checks++;
      if (ev_q.size() != 3 || ev_q[0] != 1 || ev_q[1] != 1 || ev_q[2] != 2) begin
         errors++; $display("FAIL drain_sequence: got %0d commands required START,START,SET_COUNT", ev_q.size());
      end
      $display("drain commands=%0d", ev_q.size());
      ref_iv = iv_b; ref_pos = 0;
      d = rand128();
      word_check("post_drain", d, d ^ ks_word(ref_key, ref_iv, 0), 0);
   endtask

   task automatic test_backpressure();
      logic [127:0] d, expv;
      int lat;
      bit ok;
      d = rand128();
      expv = d ^ ks_word(ref_key, ref_iv, ref_pos);
      send_word(d, lat, ok);
      ev_q.delete();
      @(negedge CLK); IN_VALID = 1'b1; IN_DATA = rand128();
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK); #1;
         checks++;
         if (OUT_DATA !== expv || OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL hold_out: cycle %0d got %h/%b required %h/1", c, OUT_DATA, OUT_VALID, expv);
         end
         checks++;
         if (IN_READY !== 1'b0 || CFG_READY !== 1'b0) begin
            errors++; $display("FAIL hold_ready: cycle %0d got in=%b cfg=%b required 0/0", c, IN_READY, CFG_READY);
         end
      end
      IN_VALID = 1'b0;
      checks++;
      if (ev_q.size() != 0) begin errors++; $display("FAIL hold_pulses: got %0d required 0", ev_q.size()); end
      $display("backpressure out=%h", OUT_DATA);
      take_out(0);
      ref_pos++;
   endtask

   task automatic test_priority();
      logic [255:0] k_new;
      logic [127:0] d;
      bit ok;
      int n = 0;
      cfg_load(1'b1, '0, ref_iv, ok);
      ref_pos = 0;
      ev_q.delete();
      k_new = rand256();
      @(negedge CLK); CFG_KEY = 1'b1; KEY_IN = k_new; IN_VALID = 1'b1; IN_DATA = rand128(); #1;
      checks++;
      if (IN_READY !== 1'b0) begin errors++; $display("FAIL prio_in_ready: got %b required 0", IN_READY); end
      @(posedge CLK); #1; CFG_KEY = 1'b0; IN_VALID = 1'b0;
      while (!CFG_READY && n < 400) begin @(negedge CLK); n++; end
      checks++;
      if (ev_q.size() != 1 || ev_q[0] != 3) begin
         errors++; $display("FAIL prio_commands: got %0d commands required one SET_KEY", ev_q.size());
      end
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL prio_no_word: got %b required 0", OUT_VALID); end
      $display("priority key loaded, commands=%0d", ev_q.size());
      ref_key = k_new;
      d = rand128();
      word_check("new_key", d, d ^ ks_word(ref_key, ref_iv, ref_pos), 0);
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      cfg_load(1'b1, '0, ref_iv, ok);
      ref_pos = 0;
      accept_word(rand128(), ok);
      repeat (5) @(posedge CLK);
      #3; RST_N = 1'b0; #1;
      checks++;
      if ({OUT_VALID, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, IN_READY} !== 6'b0 || CFG_READY !== 1'b1) begin
         errors++; $display("FAIL async_reset_flags: got %b%b required 0000001",
                            {OUT_VALID, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, IN_READY}, CFG_READY);
      end
      checks++;
      if ({OUT_DATA, CORE_KEY_IN, CORE_DATA_IN} !== '0) begin errors++; $display("FAIL async_reset_data: got nonzero required 0"); end
      $display("reset asserted mid-wait");
      @(negedge CLK); RST_N = 1'b1;
      ref_key = '0; ref_iv = '0; ref_pos = 0;
   endtask

`ifdef SALSA_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      logic [127:0] d;
      bit ok, saw_out;
      saw_out = 1'b0;
      load_key_iv(rand256(), rand128());
      stuck = 1'b1;
      accept_word(rand128(), ok);
      for (int e = 1; e <= 80; e++) begin
         @(posedge CLK); #1;
         if (OUT_VALID) saw_out = 1'b1;
         if (e == 60) begin
            checks++;
            if (ERR !== 1'b0) begin errors++; $display("FAIL timeout_early: got ERR=%b required 0", ERR); end
         end
      end
      checks++;
      if (ERR !== 1'b1 || saw_out) begin errors++; $display("FAIL timeout_err: got ERR=%b out=%b required 1/0", ERR, saw_out); end
      checks++;
      if (IN_READY !== 1'b0 || CFG_READY !== 1'b1) begin
         errors++; $display("FAIL timeout_idle: got in=%b cfg=%b required 0/1", IN_READY, CFG_READY);
      end
      stuck = 1'b0;
      cfg_load(1'b0, ref_key, '0, ok);
      #1;
      checks++;
      if (IN_READY !== 1'b0) begin errors++; $display("FAIL timeout_key_only: got %b required 0", IN_READY); end
      cfg_load(1'b1, '0, ref_iv, ok);
      #1;
      checks++;
      if (IN_READY !== 1'b1 || ERR !== 1'b1) begin
         errors++; $display("FAIL timeout_reload: got in=%b err=%b required 1/1", IN_READY, ERR);
      end
      $display("timeout ERR=%b", ERR);
      ref_pos = 0;
      d = rand128();
      word_check("after_timeout", d, d ^ ks_word(ref_key, ref_iv, 0), 0);
   endtask
`else
   task automatic test_no_timeout();
      logic [127:0] d;
      bit ok;
      int n = 0;
      load_key_iv(rand256(), rand128());
      stuck = 1'b1;
      d = rand128();
      accept_word(d, ok);
      repeat (100) @(posedge CLK);
      #1;
      checks++;
      if (OUT_VALID !== 1'b0 || ERR !== 1'b0) begin
         errors++; $display("FAIL long_busy: got out=%b err=%b required 0/0", OUT_VALID, ERR);
      end
      stuck = 1'b0;
      while (!OUT_VALID && n < 50) begin @(posedge CLK); #1; n++; end
      checks++;
      if (OUT_DATA !== (d ^ ks_word(ref_key, ref_iv, 0)) || OUT_VALID !== 1'b1) begin
         errors++; $display("FAIL long_busy_data: got %h required %h", OUT_DATA, d ^ ks_word(ref_key, ref_iv, 0));
      end
      $display("long busy out=%h err=%b", OUT_DATA, ERR);
      take_out(0);
   endtask
`endif

   initial begin
      test_reset();
      test_zero_keystream();
      test_decrypt_latency();
      test_random();
      test_iv_drain();
      test_backpressure();
      test_priority();
      test_reset_mid_wait();
`ifdef SALSA_CTRL_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "simulation time limit");
   end

endmodule
